ma_pass_scheduler: RTL and testbench

- Sequences the multiply-adder tree for one convolution layer.
- Issues window/kernel buffer addresses once per cycle. Splits each output pixel into cfg_num_passes tree-sized chunks.
- Tracks the fixed, non-stallable tree latency with a tag pipeline. Accumulates partial sums per pixel and delivers finished pixels through a valid/ready output backed by a small result FIFO.
- Sits between the layer control FSM and the mult_adder / window buffer / kernel buffer.

---
 rtl/ma_sched_pkg.sv | 21 ++
 rtl/ma_result_fifo.sv | 57 +++++
 rtl/ma_pass_scheduler.sv | 133 +++++++++++++
 tb/tb_ma_pass_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_sched_pkg.sv
// rtl/ma_sched_pkg.sv - shared types and defaults for the multiply-adder pass scheduler
package ma_sched_pkg;

   localparam int MA_TREE_SIZE   = 8;
   // One multiply stage, one stage per adder level, one output register.
   localparam int MA_LATENCY_DEF = 1 + $clog2(MA_TREE_SIZE) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } ma_tag_t;

endpackage

// File: rtl/ma_result_fifo.sv
// rtl/ma_result_fifo.sv - result FIFO between the pixel accumulator and the output handshake
module ma_result_fifo
   import ma_sched_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter int  W     = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [W-1:0]  push_data_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic          valid_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_pop;

   assign do_pop = pop_i && (count_q != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

   // The scheduler's credit scheme guarantees a free slot for every retiring pixel.
   push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && (count_q == FULL_CNT)));

endmodule

// File: rtl/ma_pass_scheduler.sv
// rtl/ma_pass_scheduler.sv - issues multiply-adder passes per output pixel and accumulates results
module ma_pass_scheduler
   import ma_sched_pkg::*;
#(
   parameter int MA_LATENCY = MA_LATENCY_DEF,
   parameter int ADDR_W     = 12,
   parameter int CNT_W      = 12,
   parameter int PASS_W     = 4,
   parameter int OUT_DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic [CNT_W-1:0]  cfg_num_pixels,
   input  logic [PASS_W-1:0] cfg_num_passes,
   output logic              busy,
   output logic              done,
   output logic              ma_issue,
   output logic [ADDR_W-1:0] win_addr,
   output logic [ADDR_W-1:0] kern_addr,
   input  logic [31:0]       ma_out,
   output logic [31:0]       res_data,
   output logic              res_valid,
   input  logic              res_ready
);

   localparam int OCW = $clog2(OUT_DEPTH) + 1;

   sched_state_e      state_q, state_d;
   logic [CNT_W-1:0]  pixels_q, pix_q;
   logic [PASS_W-1:0] passes_q, pass_q;
   logic [ADDR_W-1:0] addr_q;
   logic [OCW-1:0]    inflight_q, fifo_count;
   ma_tag_t           tag_q [MA_LATENCY];
   ma_tag_t           tag_out;
   logic [31:0]       acc_q, sum;
   logic              done_q;
   logic              first_pass, last_pass, last_pixel, credit, issue, retire, tags_empty;

   assign first_pass = (pass_q == '0);
   assign last_pass  = (pass_q == passes_q - 1'b1);
   assign last_pixel = (pix_q == pixels_q - 1'b1);
   // Pixels in the tree plus parked results may never exceed the FIFO slots.
   assign credit     = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (OCW + 1)'(OUT_DEPTH);
   assign issue      = (state_q == ST_RUN) && (!first_pass || credit);
   assign tag_out    = tag_q[MA_LATENCY-1];
   assign retire     = tag_out.valid && tag_out.last;
   assign sum        = tag_out.first ? ma_out : acc_q + ma_out;

   always_comb begin
      tags_empty = 1'b1;
      for (int i = 0; i < MA_LATENCY; i++) begin
         if (tag_q[i].valid) tags_empty = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cfg_start) state_d = (cfg_num_pixels == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (issue && last_pass && last_pixel) state_d = ST_DRAIN;
         ST_DRAIN: if (tags_empty && (inflight_q == '0) && !res_valid) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         done_q     <= 1'b0;
         pixels_q   <= '0;
         passes_q   <= '0;
         pix_q      <= '0;
         pass_q     <= '0;
         addr_q     <= '0;
         inflight_q <= '0;
         acc_q      <= '0;
         for (int i = 0; i < MA_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_DONE);

         if ((state_q == ST_IDLE) && cfg_start) begin
            pixels_q <= cfg_num_pixels;
            passes_q <= (cfg_num_passes == '0) ? PASS_W'(1) : cfg_num_passes;
            pix_q    <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
         end else if (issue) begin
            addr_q <= addr_q + 1'b1;
            if (last_pass) begin
               pass_q <= '0;
               pix_q  <= pix_q + 1'b1;
            end else begin
               pass_q <= pass_q + 1'b1;
            end
         end

         tag_q[0] <= issue ? ma_tag_t'{valid: 1'b1, first: first_pass, last: last_pass} : '0;
         for (int i = 1; i < MA_LATENCY; i++) tag_q[i] <= tag_q[i-1];

         if (tag_out.valid) acc_q <= sum;

         case ({issue && first_pass, retire})
            2'b10:   inflight_q <= inflight_q + 1'b1;
            2'b01:   inflight_q <= inflight_q - 1'b1;
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   ma_result_fifo #(
      .DEPTH (OUT_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk_i       (clock),
      .rst_ni      (reset),
      .push_i      (retire),
      .push_data_i (sum),
      .pop_i       (res_ready),
      .head_o      (res_data),
      .valid_o     (res_valid),
      .count_o     (fifo_count)
   );

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign ma_issue  = issue;
   assign win_addr  = addr_q;
   assign kern_addr = ADDR_W'(pass_q);

endmodule

// File: tb/tb_ma_pass_scheduler.sv
// tb/tb_ma_pass_scheduler.sv - self-checking bench for ma_pass_scheduler
module tb_ma_pass_scheduler;

   localparam int L = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_start = 1'b0;
   logic [11:0] cfg_num_pixels = '0;
   logic [3:0]  cfg_num_passes = '0;
   logic        busy, done, ma_issue;
   logic [11:0] win_addr, kern_addr;
   logic [31:0] ma_out = '0;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_ready = 1'b1;

   ma_pass_scheduler #(
      .MA_LATENCY (L),
      .ADDR_W     (12),
      .CNT_W      (12),
      .PASS_W     (4),
      .OUT_DEPTH  (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cfg_start      (cfg_start),
      .cfg_num_pixels (cfg_num_pixels),
      .cfg_num_passes (cfg_num_passes),
      .busy           (busy),
      .done           (done),
      .ma_issue       (ma_issue),
      .win_addr       (win_addr),
      .kern_addr      (kern_addr),
      .ma_out         (ma_out),
      .res_data       (res_data),
      .res_valid      (res_valid),
      .res_ready      (res_ready)
   );

   always #5 clock = ~clock;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] val_tab [64];
   logic [31:0] dly [6];
   int          drv_idx = 0, mon_idx = 0, m_total = 0, m_passes = 1, cyc = 0;
   int          first_valid_cyc = -1, first_done_cyc = -1;
   bit          mon_en = 1'b0, saw_done = 1'b0, prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_got(input string name, input int idx, input logic [31:0] val);
      if (idx < got_q.size()) check(name, got_q[idx], val);
      else check(name, got_q.size(), idx + 1);
   endtask

   // Expected pixel values: plain sum of each pixel's pass values, modulo 2^32.
   task automatic model_start(input int px, input int ps);
      logic [31:0] s;
      m_passes = (ps == 0) ? 1 : ps;
      m_total  = px * m_passes;
      exp_q.delete();
      got_q.delete();
      for (int p = 0; p < px; p++) begin
         s = '0;
         for (int k = 0; k < m_passes; k++) s = s + val_tab[p*m_passes + k];
         exp_q.push_back(s);
      end
      for (int i = 0; i < 6; i++) dly[i] = '0;
      mon_idx = 0;
      drv_idx = 0;
      cyc = 0;
      first_valid_cyc = -1;
      first_done_cyc = -1;
      saw_done = 1'b0;
      prev_stall = 1'b0;
      mon_en = 1'b1;
   endtask

   // One clock cycle: compare at the falling edge, model the tree, return just after the rising edge.
   task automatic tick();
      @(negedge clock);
      if (mon_en) begin
         if ((mon_idx % m_passes != 0) && (mon_idx < m_total)) check("contiguous_issue", ma_issue, 1);
         if (ma_issue) begin
            check("issue_budget", mon_idx < m_total, 1);
            check("win_addr", win_addr, mon_idx);
            check("kern_addr", kern_addr, mon_idx % m_passes);
            mon_idx++;
         end
         if (prev_stall) begin
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, prev_data);
         end
         if (res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) check("extra_result", exp_q.size(), 1);
            else check("res_data", res_data, exp_q.pop_front());
            got_q.push_back(res_data);
         end
         prev_stall = res_valid && !res_ready;
         prev_data  = res_data;
         if (done && !saw_done) begin
            saw_done = 1'b1;
            first_done_cyc = cyc;
         end
         cyc++;
      end
      for (int i = 5; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = 32'hDEAD_BEEF;
      if (ma_issue) begin
         dly[0] = (drv_idx < 64) ? val_tab[drv_idx] : '0;
         drv_idx++;
      end
      ma_out = dly[5];
      @(posedge clock);
      #1;
   endtask

   task automatic start_job(input int px, input int ps);
      cfg_num_pixels = 12'(px);
      cfg_num_passes = 4'(ps);
      cfg_start = 1'b1;
      model_start(px, ps);
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic finish_job(input int budget);
      int n;
      n = 0;
      while (!saw_done && n < budget) begin
         tick();
         n++;
      end
      check("done_seen", saw_done, 1);
      check("results_left", exp_q.size(), 0);
      check("issue_count", mon_idx, m_total);
      check("idle_after_done", busy, 0);
      mon_en = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 6; i++) dly[i] = '0;
      for (int i = 0; i < 64; i++) val_tab[i] = '0;
      repeat (3) tick();
      check("reset_ctrl", {busy, done, ma_issue, res_valid, win_addr, kern_addr}, 0);
      check("reset_data", res_data, 0);
      reset = 1'b1;
      tick();

      // single pass, ma_out = issue index + 10
      for (int i = 0; i < 64; i++) val_tab[i] = 32'(i + 10);
      start_job(3, 1);
      check("busy_after_start", busy, 1);
      finish_job(100);
      check("t1_latency", first_valid_cyc, 7);
      check_got("t1_r0", 0, 10);
      check_got("t1_r1", 1, 11);
      check_got("t1_r2", 2, 12);

      // multi pass, constant 100 per pass
      for (int i = 0; i < 64; i++) val_tab[i] = 32'd100;
      start_job(2, 3);
      finish_job(100);
      check("t2_latency", first_valid_cyc, 9);
      check_got("t2_r0", 0, 300);
      check_got("t2_r1", 1, 300);

      // backpressure: only four pixels may be outstanding
      for (int i = 0; i < 64; i++) val_tab[i] = 32'(i + 20);
      res_ready = 1'b0;
      start_job(8, 1);
      repeat (20) tick();
      check("bp_issues", mon_idx, 4);
      check("bp_stalled", ma_issue, 0);
      check("bp_valid", res_valid, 1);
      res_ready = 1'b1;
      finish_job(200);
      for (int i = 0; i < 8; i++) check_got("bp_result", i, 32'(i + 20));

      // zero pixels
      start_job(0, 3);
      finish_job(20);
      check("zero_px_done_cyc", first_done_cyc, 2);
      check("zero_px_issues", mon_idx, 0);

      // zero passes behaves as one
      val_tab[0] = 32'd7;
      val_tab[1] = 32'd9;
      start_job(2, 0);
      finish_job(100);
      check_got("p0_r0", 0, 7);
      check_got("p0_r1", 1, 9);

      // 32-bit wrap
      val_tab[0] = 32'hFFFF_FFFF;
      val_tab[1] = 32'd2;
      start_job(1, 2);
      finish_job(100);
      check_got("wrap", 0, 1);

      // reset mid-job with results parked in the FIFO
      for (int i = 0; i < 64; i++) val_tab[i] = 32'(i + 1);
      res_ready = 1'b0;
      start_job(5, 2);
      repeat (14) tick();
      check("pre_reset_valid", res_valid, 1);
      reset = 1'b0;
      #1;
      check("mid_reset_ctrl", {busy, done, ma_issue, res_valid, win_addr, kern_addr}, 0);
      check("mid_reset_data", res_data, 0);
      mon_en = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      res_ready = 1'b1;
      tick();
      val_tab[0] = 32'd5;
      val_tab[1] = 32'd6;
      val_tab[2] = 32'd7;
      val_tab[3] = 32'd8;
      start_job(2, 2);
      finish_job(100);
      check_got("fresh_r0", 0, 11);
      check_got("fresh_r1", 1, 15);

      // start while busy is ignored
      for (int i = 0; i < 64; i++) val_tab[i] = 32'(i + 1);
      start_job(3, 2);
      repeat (3) tick();
      cfg_num_pixels = 12'd7;
      cfg_num_passes = 4'd1;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      finish_job(100);
      check("sb_issues", mon_idx, 6);
      check_got("sb_r0", 0, 3);
      check_got("sb_r1", 1, 7);
      check_got("sb_r2", 2, 11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
